ahb_arbiter_m2: RTL and testbench

AHB_ARBITER_M2 -- requirements
Module: ahb_arbiter_m2

---
 rtl/ahb_arbiter_m2_if.sv | 30 +++
 rtl/ahb_arbiter_m2.sv | 109 ++++++++++
 tb/tb_ahb_arbiter_m2.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_arbiter_m2_if.sv
// Purpose : bus-side signal bundle between two AHB masters and the 2-master arbiter.
// Latency : n/a (wires only); grants/HMASTER/HMASTLOCK are registered inside the arbiter.
// Backpressure: HREADY is the only stall; the arbiter freezes all state while it is low.
//
// Ports (modports):
//   slave  - arbiter view: requests, locks, HREADY/HTRANS/HBURST in; grants, HMASTER, HMASTLOCK out.
//   master - requester/bus view: the mirror image of slave.
interface ahb_arbiter_m2_if;
    logic       HBUSREQ_0;
    logic       HBUSREQ_1;
    logic       HLOCK_0;
    logic       HLOCK_1;
    logic       HREADY;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HGRANT_0;
    logic       HGRANT_1;
    logic [3:0] HMASTER;
    logic       HMASTLOCK;

    modport slave (
        input  HBUSREQ_0, HBUSREQ_1, HLOCK_0, HLOCK_1, HREADY, HTRANS, HBURST,
        output HGRANT_0, HGRANT_1, HMASTER, HMASTLOCK
    );

    modport master (
        output HBUSREQ_0, HBUSREQ_1, HLOCK_0, HLOCK_1, HREADY, HTRANS, HBURST,
        input  HGRANT_0, HGRANT_1, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb_arbiter_m2.sv
// Purpose : 2-master AHB arbiter, round-robin with bus parking, burst-aware handover and lock support.
// Latency : grant changes at the edge accepting the next-to-last fixed-burst beat; HMASTER/HMASTLOCK follow one HREADY edge later.
// Backpressure: HREADY=0 freezes beat counter, grant, HMASTER and HMASTLOCK for any number of cycles.
//
// Ports:
//   HCLK     - bus clock, all state on rising edge
//   HRESETn  - asynchronous active-low reset
//   bus      - ahb_arbiter_m2_if.slave: HBUSREQ_x, HLOCK_x, HREADY, HTRANS, HBURST in;
//              HGRANT_x (one-hot), HMASTER (4'h0/4'h1), HMASTLOCK out
module ahb_arbiter_m2 #(
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahb_arbiter_m2_if.slave   bus
);

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

    localparam owner_e DEF_OWNER = (DEFAULT_MASTER != 0) ? OWN_M1 : OWN_M0;

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_BUSY   = 2'd1;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;

    owner_e     gnt_q, gnt_d;
    owner_e     last_q, last_d;
    logic [4:0] cnt_q, cnt_d;
    logic       hmaster_q, hmaster_d;
    logic       mlock_q, mlock_d;

    owner_e     pick;
    logic       lock_cur;
    logic       req_any;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            gnt_q     <= DEF_OWNER;
            last_q    <= DEF_OWNER;
            cnt_q     <= 5'd0;
            hmaster_q <= (DEF_OWNER == OWN_M1);
            mlock_q   <= 1'b0;
        end else begin
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            hmaster_q <= hmaster_d;
            mlock_q   <= mlock_d;
        end
    end

    always_comb begin
        gnt_d     = gnt_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        hmaster_d = hmaster_q;
        mlock_d   = mlock_q;
        pick      = DEF_OWNER;
        lock_cur  = (gnt_q == OWN_M1) ? bus.HLOCK_1 : bus.HLOCK_0;
        req_any   = bus.HBUSREQ_0 | bus.HBUSREQ_1;

        if (bus.HREADY) begin
            // cnt holds the number of beats still to come after the one being accepted.
            unique case (bus.HTRANS)
                TR_IDLE:   cnt_d = 5'd0;
                TR_BUSY:   cnt_d = cnt_q;
                TR_NONSEQ: begin
                    unique case (bus.HBURST)
                        3'd0, 3'd1: cnt_d = 5'd0;
                        3'd2, 3'd3: cnt_d = 5'd3;
                        3'd4, 3'd5: cnt_d = 5'd7;
                        default:    cnt_d = 5'd15;
                    endcase
                end
                TR_SEQ:    cnt_d = (cnt_q != 5'd0) ? cnt_q - 5'd1 : 5'd0;
            endcase

            // Address-phase owner is whoever held the grant going into this edge.
            hmaster_d = (gnt_q == OWN_M1);
            mlock_d   = lock_cur;

            // cnt_d<=1 lets the grant move while the final beat's address is still
            // on the bus, so the next owner starts its address phase right after.
            if ((cnt_d <= 5'd1) && !lock_cur) begin
                unique case ({bus.HBUSREQ_1, bus.HBUSREQ_0})
                    2'b11:   pick = (last_q == OWN_M0) ? OWN_M1 : OWN_M0;
                    2'b01:   pick = OWN_M0;
                    2'b10:   pick = OWN_M1;
                    default: pick = DEF_OWNER;
                endcase
                // Parking never moves the round-robin pointer.
                if (req_any && (pick != gnt_q)) begin
                    last_d = pick;
                end
                gnt_d = pick;
            end
        end
    end

    assign bus.HGRANT_0  = (gnt_q == OWN_M0);
    assign bus.HGRANT_1  = (gnt_q == OWN_M1);
    assign bus.HMASTER   = {3'b000, hmaster_q};
    assign bus.HMASTLOCK = mlock_q;

endmodule

// File: tb/tb_ahb_arbiter_m2.sv
// Purpose : self-checking bench for ahb_arbiter_m2 (directed table, corner sequences, random vs reference model).
// Latency : outputs compared 1 time unit after each rising edge.
// Backpressure: HREADY driven directly; stalls exercised in table, sequences and random phase.
module tb_ahb_arbiter_m2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ahb_arbiter_m2_if bus();

    ahb_arbiter_m2 #(.DEFAULT_MASTER(0)) dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus.slave)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: owner, round-robin pointer, beats left, registered outputs.
    int m_cnt;
    bit m_gnt, m_last, m_hm, m_ml;

    int cyc, g1_rise, hm1_rise;

    typedef struct {
        bit         r0, r1, l0, l1, rdy;
        logic [1:0] tr;
        logic [2:0] bu;
        bit         eg;
        logic [3:0] ehm;
        bit         eml;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input bit r0, r1, l0, l1, rdy, input logic [1:0] tr,
                                input logic [2:0] bu, input bit eg, input logic [3:0] ehm, input bit eml);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1; v.rdy = rdy;
        v.tr = tr; v.bu = bu; v.eg = eg; v.ehm = ehm; v.eml = eml;
        return v;
    endfunction

    function automatic int blen(input logic [2:0] b);
        case (b)
            3'd0, 3'd1: return 1;
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default:    return 16;
        endcase
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_gnt = 1'b0; m_last = 1'b0; m_hm = 1'b0; m_ml = 1'b0;
    endtask

    task automatic model_edge(input bit r0, r1, l0, l1, rdy, input logic [1:0] tr, input logic [2:0] bu);
        bit lk[2];
        int nxt;
        bit pick;
        if (!rdy) return;
        lk[0] = l0; lk[1] = l1;
        case (tr)
            2'd0:    nxt = 0;
            2'd1:    nxt = m_cnt;
            2'd2:    nxt = blen(bu) - 1;
            default: nxt = (m_cnt > 0) ? m_cnt - 1 : 0;
        endcase
        m_hm = m_gnt;
        m_ml = lk[m_gnt];
        if (nxt <= 1 && !lk[m_gnt]) begin
            if (r0 && r1)  pick = ~m_last;
            else if (r0)   pick = 1'b0;
            else if (r1)   pick = 1'b1;
            else           pick = 1'b0;
            if ((r0 || r1) && pick != m_gnt) m_last = pick;
            m_gnt = pick;
        end
        m_cnt = nxt;
    endtask

    task automatic check_vals(input string name, input bit eg, input logic [3:0] ehm, input bit eml);
        n_vec++;
        if (bus.HGRANT_0 !== ~eg || bus.HGRANT_1 !== eg || bus.HMASTER !== ehm || bus.HMASTLOCK !== eml) begin
            n_bad++;
            $display("FAIL %s @%0t: got g0=%b g1=%b hmaster=%h mlock=%b, want g0=%b g1=%b hmaster=%h mlock=%b",
                     name, $time, bus.HGRANT_0, bus.HGRANT_1, bus.HMASTER, bus.HMASTLOCK, ~eg, eg, ehm, eml);
        end
    endtask

    task automatic check_model(input string name);
        check_vals(name, m_gnt, {3'b000, m_hm}, m_ml);
    endtask

    task automatic cmp_int(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic drive(input bit r0, r1, l0, l1, rdy, input logic [1:0] tr, input logic [2:0] bu);
        bus.HBUSREQ_0 = r0; bus.HBUSREQ_1 = r1;
        bus.HLOCK_0   = l0; bus.HLOCK_1   = l1;
        bus.HREADY    = rdy;
        bus.HTRANS    = tr; bus.HBURST    = bu;
    endtask

    // One bus cycle: apply inputs, advance model, clock, compare against model.
    task automatic step(input bit r0, r1, l0, l1, rdy, input logic [1:0] tr, input logic [2:0] bu,
                        input string name);
        drive(r0, r1, l0, l1, rdy, tr, bu);
        model_edge(r0, r1, l0, l1, rdy, tr, bu);
        @(posedge clk);
        #1;
        cyc++;
        check_model(name);
        if (g1_rise < 0 && bus.HGRANT_1 === 1'b1) g1_rise = cyc;
        if (hm1_rise < 0 && bus.HMASTER === 4'h1) hm1_rise = cyc;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 1, 2'd0, 3'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset_state");
        rst_n = 1'b1;
        cyc = 0; g1_rise = -1; hm1_rise = -1;
    endtask

    // INCR4 from master 0 with master 1 waiting; optional stall on beat 2.
    task automatic incr4_handover(input int stall, output int rise, output int hmr);
        reset_dut();
        step(1, 0, 0, 0, 1, 2'd0, 3'd0, "incr4_pre");
        cyc = 0; g1_rise = -1; hm1_rise = -1;
        step(1, 1, 0, 0, 1, 2'd2, 3'd3, "incr4_beat1");
        for (int i = 0; i < stall; i++) step(0, 1, 0, 0, 0, 2'd3, 3'd3, "incr4_stall");
        step(0, 1, 0, 0, 1, 2'd3, 3'd3, "incr4_beat2");
        step(0, 1, 0, 0, 1, 2'd3, 3'd3, "incr4_beat3");
        step(0, 1, 0, 0, 1, 2'd3, 3'd3, "incr4_beat4");
        step(0, 1, 0, 0, 1, 2'd0, 3'd0, "incr4_idle");
        rise = g1_rise;
        hmr  = hm1_rise;
    endtask

    initial begin
        int rise0, hm0r, rise3, hm3r, locked;
        bit r0, r1, l0, l1, rdy;
        logic [1:0] tr;
        logic [2:0] bu;

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 1, 2'd0, 3'd0);
        cyc = 0; g1_rise = -1; hm1_rise = -1;

        //            r0 r1 l0 l1 rdy tr    bu      g  hm    ml
        tbl[0]  = mk(0, 0, 0, 0, 1, 2'd0, 3'd0,  0, 4'h0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 1, 2'd0, 3'd0,  0, 4'h0, 0);
        tbl[2]  = mk(1, 1, 0, 0, 1, 2'd2, 3'd0,  1, 4'h0, 0);
        tbl[3]  = mk(1, 1, 0, 0, 1, 2'd2, 3'd0,  0, 4'h1, 0);
        tbl[4]  = mk(1, 1, 0, 0, 1, 2'd2, 3'd0,  1, 4'h0, 0);
        tbl[5]  = mk(1, 1, 0, 0, 1, 2'd2, 3'd0,  0, 4'h1, 0);
        tbl[6]  = mk(1, 1, 0, 0, 1, 2'd2, 3'd3,  0, 4'h0, 0);
        tbl[7]  = mk(0, 1, 0, 0, 1, 2'd3, 3'd3,  0, 4'h0, 0);
        tbl[8]  = mk(0, 1, 0, 0, 1, 2'd3, 3'd3,  1, 4'h0, 0);
        tbl[9]  = mk(0, 1, 0, 0, 1, 2'd3, 3'd3,  1, 4'h1, 0);
        tbl[10] = mk(0, 1, 0, 0, 1, 2'd0, 3'd0,  1, 4'h1, 0);
        tbl[11] = mk(1, 1, 0, 1, 1, 2'd0, 3'd0,  1, 4'h1, 1);
        tbl[12] = mk(1, 1, 0, 1, 1, 2'd0, 3'd0,  1, 4'h1, 1);
        tbl[13] = mk(1, 1, 0, 0, 1, 2'd0, 3'd0,  0, 4'h1, 0);
        tbl[14] = mk(0, 0, 0, 0, 1, 2'd0, 3'd0,  0, 4'h0, 0);
        tbl[15] = mk(1, 1, 0, 0, 1, 2'd2, 3'd7,  0, 4'h0, 0);
        tbl[16] = mk(1, 1, 0, 0, 1, 2'd1, 3'd7,  0, 4'h0, 0);
        tbl[17] = mk(1, 1, 0, 0, 0, 2'd3, 3'd7,  0, 4'h0, 0);
        tbl[18] = mk(0, 0, 0, 0, 1, 2'd0, 3'd0,  0, 4'h0, 0);

        repeat (2) @(posedge clk);
        #1;
        check_vals("reset_values", 1'b0, 4'h0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].r0, tbl[i].r1, tbl[i].l0, tbl[i].l1, tbl[i].rdy, tbl[i].tr, tbl[i].bu);
            @(posedge clk);
            #1;
            check_vals($sformatf("table_%0d", i), tbl[i].eg, tbl[i].ehm, tbl[i].eml);
        end

        // Fixed-burst handover, then the same burst with a 3-cycle stall on beat 2.
        incr4_handover(0, rise0, hm0r);
        cmp_int("incr4_grant_edge", rise0, 3);
        cmp_int("incr4_hmaster_edge", hm0r, 4);
        incr4_handover(3, rise3, hm3r);
        cmp_int("stall_grant_edge", rise3, 6);
        cmp_int("stall_hmaster_edge", hm3r, 7);
        cmp_int("stall_delay", rise3 - rise0, 3);

        // Locked ownership by master 1 while master 0 keeps requesting.
        reset_dut();
        step(0, 1, 0, 0, 1, 2'd0, 3'd0, "lock_take");
        locked = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, 1, 1, 2'd2, 3'd0, "lock_hold");
            if (bus.HGRANT_1 === 1'b1 && bus.HMASTLOCK === 1'b1) locked++;
        end
        cmp_int("lock_cycles_held", locked, 10);
        step(1, 1, 0, 0, 1, 2'd0, 3'd0, "lock_release");
        cmp_int("lock_release_g0", int'(bus.HGRANT_0), 1);

        // Asynchronous reset in the middle of an INCR8 from master 1.
        reset_dut();
        step(0, 1, 0, 0, 1, 2'd0, 3'd0, "rst_burst_take");
        step(0, 1, 0, 0, 1, 2'd2, 3'd5, "rst_burst_b1");
        step(0, 1, 0, 0, 1, 2'd3, 3'd5, "rst_burst_b2");
        step(0, 1, 0, 0, 1, 2'd3, 3'd5, "rst_burst_b3");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_model("rst_mid_burst_async");
        @(negedge clk);
        rst_n = 1'b1;
        // A stale counter would block this rearbitration.
        step(0, 1, 0, 0, 1, 2'd3, 3'd5, "rst_first_edge_cnt0");

        // Randomized traffic against the reference model, with occasional async resets.
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                #1 rst_n = 1'b0;
                #1;
                model_reset();
                check_model("rand_reset");
                #1 rst_n = 1'b1;
            end
            r0  = 1'($urandom_range(0, 1));
            r1  = 1'($urandom_range(0, 1));
            l0  = ($urandom_range(0, 7) == 0);
            l1  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            tr  = 2'($urandom_range(0, 3));
            bu  = 3'($urandom_range(0, 7));
            step(r0, r1, l0, l1, rdy, tr, bu, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
